// File: rtl/fru_cfg_pkg.sv
// ---------------------------------------------------------------------------
// fru_cfg_pkg
// Shared types and constants for the filter-reduce-unit configuration
// sequencer: controller state encoding, the idle configId value and the
// FIFO entry layout (image byte plus end-of-image flag).
// ---------------------------------------------------------------------------
package fru_cfg_pkg;

   // Sequencer states, in the order an image moves through them.
   typedef enum logic [2:0] {
      LOAD   = 3'd0,
      DRAIN  = 3'd1,
      GAP    = 3'd2,
      STREAM = 3'd3,
      RESUME = 3'd4
   } cfg_state_t;

   // configId value that no unit answers to.
   localparam logic [7:0] CFG_IDLE_ID = 8'hFF;

   // One buffered image byte and whether it closes the image.
   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } cfg_entry_t;

   // Tracing is held low from the GAP cycle through the RESUME cycle.
   function automatic logic cfg_tracing_off(input cfg_state_t st);
      logic off;
      case (st)
         GAP, STREAM, RESUME: off = 1'b1;
         default:             off = 1'b0;
      endcase
      return off;
   endfunction

endpackage

// File: rtl/cfg_byte_fifo.sv
// ---------------------------------------------------------------------------
// cfg_byte_fifo
// Synchronous show-ahead FIFO of cfg_entry_t. The oldest entry is always
// presented on 'head' straight from the storage registers, so a pop and the
// consumer's capture of 'head' happen on the same edge.
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset (empties the FIFO)
//   flush      in   synchronous empty, has priority over push/pop
//   push       in   write push_data (ignored when full)
//   push_data  in   entry to write
//   pop        in   drop the head entry (ignored when empty)
//   head       out  oldest entry, valid while !empty
//   full       out  DEPTH entries stored
//   empty      out  no entries stored
//   count      out  number of entries stored
// ---------------------------------------------------------------------------
module cfg_byte_fifo
   import fru_cfg_pkg::*;
#(
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CNTW  = AW + 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            flush,
   input  logic            push,
   input  cfg_entry_t      push_data,
   input  logic            pop,
   output cfg_entry_t      head,
   output logic            full,
   output logic            empty,
   output logic [CNTW-1:0] count
);

   localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(DEPTH);

   cfg_entry_t      mem_r [DEPTH];
   logic [CNTW-1:0] wr_ptr_r;
   logic [CNTW-1:0] rd_ptr_r;
   logic            push_ok_s;
   logic            pop_ok_s;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign count     = wr_ptr_r - rd_ptr_r;
   assign full      = (count == FULL_COUNT);
   assign empty     = (count == {CNTW{1'b0}});
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;
   assign head      = mem_r[rd_ptr_r[AW-1:0]];

   // Storage write; contents need no reset because empty gates every read.
   always_ff @(posedge clk) begin
      if (push_ok_s && !flush) begin
         mem_r[wr_ptr_r[AW-1:0]] <= push_data;
      end
   end

   // Read/write pointer update with flush taking priority.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= {CNTW{1'b0}};
         rd_ptr_r <= {CNTW{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {CNTW{1'b0}};
         rd_ptr_r <= {CNTW{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + CNTW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + CNTW'(1);
         end
      end
   end

endmodule

// File: rtl/fru_config_sequencer.sv
// ---------------------------------------------------------------------------
// fru_config_sequencer
// Buffers a configuration image from the host while tracing runs, then
// stalls upstream input, drains the pipeline, drops tracing, streams the
// image one byte per cycle on configId/configData and restores tracing.
//
// Ports:
//   clk           in   clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   host_valid    in   host byte valid
//   host_ready    out  byte accepted when host_valid & host_ready (registered)
//   host_data     in   image byte
//   host_unit_id  in   target configId, sampled with an image's first byte
//   host_last     in   final byte of the image
//   stall_in      out  holds upstream valid_in off
//   tracing       out  shared tracing enable
//   configId      out  shared configuration target
//   configData    out  shared configuration byte
//   done          out  one-cycle pulse as tracing resumes
//   overflow      out  sticky: an image exceeded FIFO_DEPTH bytes
// ---------------------------------------------------------------------------
module fru_config_sequencer
   import fru_cfg_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 16,
   parameter int unsigned DRAIN_CYCLES   = 4,
   parameter logic [7:0]  IDLE_CONFIG_ID = CFG_IDLE_ID
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       host_valid,
   output logic       host_ready,
   input  logic [7:0] host_data,
   input  logic [7:0] host_unit_id,
   input  logic       host_last,
   output logic       stall_in,
   output logic       tracing,
   output logic [7:0] configId,
   output logic [7:0] configData,
   output logic       done,
   output logic       overflow
);

   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNTW = AW + 1;
   localparam int unsigned CW   = $clog2(DRAIN_CYCLES + 1);
   localparam logic [CNTW-1:0] ALMOST_FULL = CNTW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0]   DRAIN_LAST  = CW'(DRAIN_CYCLES - 1);

   cfg_state_t      state_r;
   cfg_state_t      next_state_s;
   logic [CW-1:0]   drain_cnt_r;
   logic [CW-1:0]   drain_cnt_next_s;
   logic [7:0]      unit_q_r;
   logic            open_r;
   logic            open_next_s;
   logic            last_out_r;

   logic            host_ready_r;
   logic            stall_r;
   logic            tracing_r;
   logic [7:0]      config_id_r;
   logic [7:0]      config_data_r;
   logic            done_r;
   logic            overflow_r;

   logic            accept_s;
   logic            push_s;
   logic            pop_s;
   logic            flush_s;
   logic            latch_unit_s;
   logic            set_overflow_s;
   logic            ready_next_s;

   cfg_entry_t      push_entry_s;
   cfg_entry_t      head_s;
   logic            fifo_full_s;
   logic            fifo_empty_s;
   logic [CNTW-1:0] fifo_count_s;

   assign accept_s     = host_valid & host_ready_r & (state_r == LOAD);
   assign push_entry_s = {host_last, host_data};

   cfg_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush_s),
      .push      (push_s),
      .push_data (push_entry_s),
      .pop       (pop_s),
      .head      (head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count_s)
   );

   // Next-state, FIFO control and host_ready decision.
   always_comb begin
      next_state_s     = state_r;
      drain_cnt_next_s = drain_cnt_r;
      open_next_s      = open_r;
      ready_next_s     = 1'b0;
      push_s           = 1'b0;
      pop_s            = 1'b0;
      flush_s          = 1'b0;
      latch_unit_s     = 1'b0;
      set_overflow_s   = 1'b0;

      case (state_r)
         LOAD: begin
            ready_next_s = 1'b1;
            if (accept_s) begin
               push_s = 1'b1;
               if (fifo_empty_s && !open_r) begin
                  latch_unit_s = 1'b1;
               end else begin
                  latch_unit_s = 1'b0;
               end
               if (host_last) begin
                  next_state_s     = DRAIN;
                  drain_cnt_next_s = {CW{1'b0}};
                  open_next_s      = 1'b0;
                  ready_next_s     = 1'b0;
               end else if (fifo_count_s == ALMOST_FULL) begin
                  // This byte fills the FIFO; refuse the next one so a late
                  // host_last cannot slip in before the overflow flush.
                  open_next_s  = 1'b1;
                  ready_next_s = 1'b0;
               end else begin
                  open_next_s = 1'b1;
               end
            end else if (fifo_full_s) begin
               // Full with no last byte: drop the image, host must restart.
               flush_s        = 1'b1;
               set_overflow_s = 1'b1;
               open_next_s    = 1'b0;
            end else begin
               open_next_s = open_r;
            end
         end

         DRAIN: begin
            if (drain_cnt_r == DRAIN_LAST) begin
               next_state_s = GAP;
            end else begin
               drain_cnt_next_s = drain_cnt_r + CW'(1);
            end
         end

         GAP: begin
            if (fifo_empty_s) begin
               next_state_s = RESUME;
            end else begin
               next_state_s = STREAM;
               pop_s        = 1'b1;
            end
         end

         STREAM: begin
            // The byte on configData now was popped last edge; stop after
            // the one that carried the last flag.
            if (last_out_r || fifo_empty_s) begin
               next_state_s = RESUME;
            end else begin
               pop_s = 1'b1;
            end
         end

         RESUME: begin
            next_state_s = LOAD;
            ready_next_s = 1'b1;
         end

         default: begin
            next_state_s = LOAD;
            ready_next_s = 1'b1;
         end
      endcase
   end

   // FSM state, drain counter and image bookkeeping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= LOAD;
         drain_cnt_r <= {CW{1'b0}};
         open_r      <= 1'b0;
         unit_q_r    <= IDLE_CONFIG_ID;
         last_out_r  <= 1'b0;
      end else begin
         state_r     <= next_state_s;
         drain_cnt_r <= drain_cnt_next_s;
         open_r      <= open_next_s;
         unit_q_r    <= latch_unit_s ? host_unit_id : unit_q_r;
         last_out_r  <= pop_s ? head_s.last : 1'b0;
      end
   end

   // Registered outputs, computed from the state being entered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         host_ready_r  <= 1'b1;
         stall_r       <= 1'b0;
         tracing_r     <= 1'b1;
         config_id_r   <= IDLE_CONFIG_ID;
         config_data_r <= 8'h00;
         done_r        <= 1'b0;
         overflow_r    <= 1'b0;
      end else begin
         host_ready_r  <= ready_next_s;
         stall_r       <= (next_state_s != LOAD);
         tracing_r     <= ~cfg_tracing_off(next_state_s);
         // configId names the unit only alongside a freshly popped byte.
         config_id_r   <= pop_s ? unit_q_r : IDLE_CONFIG_ID;
         config_data_r <= pop_s ? head_s.data : 8'h00;
         done_r        <= (state_r == RESUME) && (next_state_s == LOAD);
         overflow_r    <= overflow_r | set_overflow_s;
      end
   end

   assign host_ready = host_ready_r;
   assign stall_in   = stall_r;
   assign tracing    = tracing_r;
   assign configId   = config_id_r;
   assign configData = config_data_r;
   assign done       = done_r;
   assign overflow   = overflow_r;

endmodule

// File: tb/tb_fru_config_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fru_config_sequencer
// Directed and randomized images; expected output timing is computed from
// the accept cycle of host_last: DRAIN for D cycles, one GAP cycle, L
// STREAM cycles, one RESUME cycle, then LOAD with done.
// ---------------------------------------------------------------------------
module tb_fru_config_sequencer;

   localparam int         D     = 4;
   localparam int         DEPTH = 16;
   localparam logic [7:0] IDLE  = 8'hFF;

   logic       clk          = 1'b0;
   logic       reset_n      = 1'b1;
   logic       host_valid   = 1'b0;
   logic [7:0] host_data    = 8'h00;
   logic [7:0] host_unit_id = 8'h00;
   logic       host_last    = 1'b0;
   logic       host_ready;
   logic       stall_in;
   logic       tracing;
   logic [7:0] configId;
   logic [7:0] configData;
   logic       done;
   logic       overflow;

   int  checks = 0;
   int  errors = 0;
   bit  exp_overflow = 1'b0;

   // Upstream pipeline model (latency 2) fed by valid_in while not stalled.
   logic       valid_in = 1'b0;
   logic [1:0] pipe     = 2'b00;
   int         injected = 0;
   int         emerged  = 0;

   logic [7:0] img  [$];
   logic [7:0] img2 [$];

   fru_config_sequencer #(
      .FIFO_DEPTH     (DEPTH),
      .DRAIN_CYCLES   (D),
      .IDLE_CONFIG_ID (IDLE)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .host_valid   (host_valid),
      .host_ready   (host_ready),
      .host_data    (host_data),
      .host_unit_id (host_unit_id),
      .host_last    (host_last),
      .stall_in     (stall_in),
      .tracing      (tracing),
      .configId     (configId),
      .configData   (configData),
      .done         (done),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      pipe <= {pipe[0], valid_in & ~stall_in};
      if (valid_in && !stall_in) injected <= injected + 1;
      if (pipe[1]) emerged <= emerged + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, ".tracing"},  tracing,    1);
      chk({tag, ".stall"},    stall_in,   0);
      chk({tag, ".configId"}, configId,   IDLE);
      chk({tag, ".ready"},    host_ready, 1);
      chk({tag, ".done"},     done,       0);
      chk({tag, ".overflow"}, overflow,   exp_overflow);
   endtask

   // Drive one image; returns one step after the edge that took the last byte.
   task automatic send_image(input logic [7:0] unit, input logic [7:0] bytes[$],
                             input int mode, input bit no_last);
      int i;
      int guard;
      bit acc;
      i = 0;
      guard = 0;
      while (i < bytes.size() && guard < 400) begin
         case (mode)
            0:       host_valid = 1'b1;
            1:       host_valid = (guard % 2 == 0);
            default: host_valid = 1'($urandom_range(0, 1));
         endcase
         host_data    = bytes[i];
         host_unit_id = (i == 0) ? unit : 8'($urandom);
         host_last    = !no_last && (i == bytes.size() - 1);
         valid_in     = 1'($urandom_range(0, 1)) & ~stall_in;
         acc          = host_valid && host_ready;
         step();
         if (acc) i++;
         guard++;
      end
      host_valid = 1'b0;
      host_last  = 1'b0;
      valid_in   = 1'b0;
      if (i < bytes.size()) chk("send_timeout", i, bytes.size());
   endtask

   // Walk the reconfiguration window from the cycle after host_last was taken.
   task automatic check_reconfig(input logic [7:0] unit, input logic [7:0] bytes[$]);
      int L;
      int fru_cnt;
      int got;
      bit streaming;
      logic [7:0] fru_mem [DEPTH];
      L = bytes.size();
      fru_cnt = 0;
      got = 0;
      for (int k = 1; k <= D + L + 3; k++) begin
         streaming = (k >= D + 2) && (k <= D + L + 1);
         chk($sformatf("stall u%0d k%0d", unit, k),   stall_in,   (k <= D + L + 2));
         chk($sformatf("tracing u%0d k%0d", unit, k), tracing,    !((k >= D + 1) && (k <= D + L + 2)));
         chk($sformatf("cfgid u%0d k%0d", unit, k),   configId,   streaming ? unit : IDLE);
         chk($sformatf("done u%0d k%0d", unit, k),    done,       (k == D + L + 3));
         chk($sformatf("ready u%0d k%0d", unit, k),   host_ready, (k == D + L + 3));
         chk($sformatf("ovf u%0d k%0d", unit, k),     overflow,   exp_overflow);
         if (streaming) chk($sformatf("data u%0d k%0d", unit, k), configData, bytes[k - D - 2]);
         if (k == D + 1) chk($sformatf("drain u%0d", unit), emerged, injected);
         // Target unit: byte counter restarts whenever configId is not its id.
         if (configId == unit) begin
            if (fru_cnt < DEPTH) fru_mem[fru_cnt] = configData;
            fru_cnt++;
            got = fru_cnt;
         end else begin
            fru_cnt = 0;
         end
         step();
      end
      chk($sformatf("fru_count u%0d", unit), got, L);
      for (int j = 0; j < L && j < got; j++)
         chk($sformatf("fru_byte u%0d i%0d", unit, j), fru_mem[j], bytes[j]);
   endtask

   initial begin
      // Reset state, asserted asynchronously between edges
      #1 reset_n = 1'b0;
      #2;
      chk("rst.tracing",  tracing,    1);
      chk("rst.stall",    stall_in,   0);
      chk("rst.configId", configId,   IDLE);
      chk("rst.data",     configData, 0);
      chk("rst.ready",    host_ready, 1);
      chk("rst.done",     done,       0);
      chk("rst.overflow", overflow,   0);
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;
      step();
      check_idle("post_reset");

      // Basic 12-byte image to unit 3
      img.delete();
      for (int i = 0; i < 12; i++) img.push_back(8'(i));
      send_image(8'd3, img, 0, 1'b0);
      check_reconfig(8'd3, img);
      check_idle("after_basic");

      // Backpressure: valid every other cycle
      img.delete();
      for (int i = 0; i < 10; i++) img.push_back(8'($urandom));
      send_image(8'd7, img, 1, 1'b0);
      check_reconfig(8'd7, img);

      // Overflow: 16 bytes without last, then a last byte while full
      img.delete();
      for (int i = 0; i < DEPTH; i++) img.push_back(8'($urandom));
      send_image(8'h11, img, 0, 1'b1);
      chk("ovf.full_ready", host_ready, 0);
      chk("ovf.not_yet",    overflow,   0);
      host_valid = 1'b1;
      host_last  = 1'b1;
      host_data  = 8'hEE;
      step();
      host_valid = 1'b0;
      host_last  = 1'b0;
      exp_overflow = 1'b1;
      chk("ovf.flag",  overflow,   1);
      chk("ovf.ready", host_ready, 1);
      chk("ovf.stall", stall_in,   0);
      step();
      chk("ovf.last_rejected", stall_in, 0);
      img.delete();
      img.push_back(8'hAA);
      img.push_back(8'hBB);
      send_image(8'd1, img, 0, 1'b0);
      check_reconfig(8'd1, img);
      check_idle("after_ovf");

      // Back-to-back images A and B
      img.delete();
      for (int i = 0; i < 4; i++) img.push_back(8'h20 + 8'(i));
      img2.delete();
      for (int i = 0; i < 3; i++) img2.push_back(8'h50 + 8'(i));
      send_image(8'd2, img, 0, 1'b0);
      check_reconfig(8'd2, img);
      send_image(8'd5, img2, 0, 1'b0);
      check_reconfig(8'd5, img2);

      // Reset during STREAM after three of eight bytes
      img.delete();
      for (int i = 0; i < 8; i++) img.push_back(8'h80 + 8'(i));
      send_image(8'd9, img, 0, 1'b0);
      for (int k = 1; k < D + 5; k++) step();
      chk("mid.streaming", configId, 8'd9);
      reset_n = 1'b0;
      exp_overflow = 1'b0;
      #1;
      chk("mid.tracing",  tracing,    1);
      chk("mid.configId", configId,   IDLE);
      chk("mid.stall",    stall_in,   0);
      chk("mid.ready",    host_ready, 1);
      chk("mid.overflow", overflow,   0);
      #1 reset_n = 1'b1;
      step();
      check_idle("mid.load");
      img.delete();
      img.push_back(8'h3C);
      img.push_back(8'hC3);
      send_image(8'd4, img, 0, 1'b0);
      check_reconfig(8'd4, img);

      // Randomized images
      for (int n = 0; n < 6; n++) begin
         int len;
         logic [7:0] u;
         len = $urandom_range(1, DEPTH);
         u   = 8'($urandom_range(0, 254));
         img.delete();
         for (int i = 0; i < len; i++) img.push_back(8'($urandom));
         send_image(u, img, 2, 1'b0);
         check_reconfig(u, img);
         check_idle($sformatf("rand%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
